stereo_line_streamer: RTL

STEREO_LINE_STREAMER -- requirements
Module: stereo_line_streamer

---
 rtl/stereo_line_streamer_pkg.sv | 24 ++
 rtl/stereo_line_streamer_timer.sv | 39 +++
 rtl/stereo_line_streamer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stereo_line_streamer_pkg.sv
// Shared post-processing definitions for the stereo line streamer: FSM encoding,
// default geometry constants and the blank-length helper.
package stereo_line_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HBLANK = 21;
    localparam int FRAC_BITS  = 1;

    // A zero blank request still costs one cycle, so the terminal count is max(hb,1)-1.
    function automatic logic [7:0] blank_len_m1(input logic [7:0] hb);
        if (hb == 8'd0) begin
            return 8'd0;
        end else begin
            return hb - 8'd1;
        end
    endfunction

endpackage

// File: rtl/stereo_line_streamer_timer.sv
// line_timer: down-counter timing the blank and active phases of a line;
// last_o flags the final cycle of the loaded phase.
module line_timer #(
    parameter int AWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [AWIDTH-1:0] load_val_i,
    output logic              last_o
);

    logic [AWIDTH-1:0] cnt_q;
    logic [AWIDTH-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {AWIDTH{1'b0}}) begin
            cnt_d = cnt_q - {{(AWIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {AWIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {AWIDTH{1'b0}});

endmodule

// File: rtl/stereo_line_streamer.sv
// Streams a stored left/right disparity frame line by line: blanking, contiguous
// memory reads, and 1-fractional-bit disparity output with pixel coordinates.
module stereo_line_streamer
    import stereo_line_streamer_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int AWIDTH = 11,
    parameter int MWIDTH = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic [AWIDTH-1:0] width,
    input  logic [AWIDTH-1:0] height,
    input  logic [7:0]        hblank,
    output logic [MWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WIDTH-2:0]  mem_L,
    input  logic [WIDTH-2:0]  mem_R,
    output logic              valid_L,
    output logic              valid_R,
    output logic [WIDTH-1:0]  disp_L,
    output logic [WIDTH-1:0]  disp_R,
    output logic              busy,
    output logic              frame_done,
    output logic [AWIDTH-1:0] x,
    output logic [AWIDTH-1:0] y
);

    state_e            state_q;
    logic [AWIDTH-1:0] w_q;
    logic [AWIDTH-1:0] h_q;
    logic [7:0]        hb_q;
    logic [AWIDTH-1:0] px_q;
    logic [AWIDTH-1:0] ln_q;
    logic [MWIDTH-1:0] addr_q;
    logic              rd_q;
    logic              busy_q;
    logic              valid_q;
    logic              fd_q;
    logic [AWIDTH-1:0] x_q;
    logic [AWIDTH-1:0] y_q;

    logic              accept_s;
    logic              last_line_s;
    logic              tmr_last_s;
    logic              tmr_load_s;
    logic [AWIDTH-1:0] tmr_val_s;

    assign accept_s    = (state_q == ST_IDLE) && !busy_q && start &&
                         (width != {AWIDTH{1'b0}}) && (height != {AWIDTH{1'b0}});
    assign last_line_s = (ln_q == (h_q - {{(AWIDTH-1){1'b0}}, 1'b1}));

    // Timer reload: blank length on frame/line start, width on entering ACTIVE.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {AWIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = AWIDTH'(blank_len_m1(hblank));
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_BLANK: begin
                if (tmr_last_s && !hold) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = w_q - {{(AWIDTH-1){1'b0}}, 1'b1};
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (tmr_last_s && !last_line_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = AWIDTH'(blank_len_m1(hb_q));
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
                tmr_val_s  = {AWIDTH{1'b0}};
            end
        endcase
    end

    line_timer #(.AWIDTH(AWIDTH)) u_line_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .last_o     (tmr_last_s)
    );

    // Frame sequencer; geometry is latched at start so later input changes are inert.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            w_q     <= {AWIDTH{1'b0}};
            h_q     <= {AWIDTH{1'b0}};
            hb_q    <= 8'd0;
            px_q    <= {AWIDTH{1'b0}};
            ln_q    <= {AWIDTH{1'b0}};
            addr_q  <= {MWIDTH{1'b0}};
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        w_q     <= width;
                        h_q     <= height;
                        hb_q    <= hblank;
                        px_q    <= {AWIDTH{1'b0}};
                        ln_q    <= {AWIDTH{1'b0}};
                        addr_q  <= {MWIDTH{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_BLANK;
                    end else if (fd_q) begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_BLANK: begin
                    if (tmr_last_s && !hold) begin
                        rd_q    <= 1'b1;
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    addr_q <= addr_q + {{(MWIDTH-1){1'b0}}, 1'b1};
                    if (tmr_last_s) begin
                        rd_q <= 1'b0;
                        px_q <= {AWIDTH{1'b0}};
                        if (last_line_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            ln_q    <= ln_q + {{(AWIDTH-1){1'b0}}, 1'b1};
                            state_q <= ST_BLANK;
                        end
                    end else begin
                        px_q <= px_q + {{(AWIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    rd_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Presentation stage aligned with the one-cycle memory read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            x_q     <= {AWIDTH{1'b0}};
            y_q     <= {AWIDTH{1'b0}};
        end else begin
            valid_q <= rd_q;
            fd_q    <= rd_q && tmr_last_s && last_line_s;
            if (rd_q) begin
                x_q <= px_q;
                y_q <= ln_q;
            end
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rd     = rd_q;
    assign valid_L    = valid_q;
    assign valid_R    = valid_q;
    assign disp_L     = valid_q ? {mem_L, {FRAC_BITS{1'b0}}} : {WIDTH{1'b0}};
    assign disp_R     = valid_q ? {mem_R, {FRAC_BITS{1'b0}}} : {WIDTH{1'b0}};
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign x          = x_q;
    assign y          = y_q;

endmodule
